// File: rtl/rf_wport_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wport_arbiter
//
// Shares the single register-file write port between two writeback sources:
//   A - in-order ALU/load pipe (normally preferred)
//   B - multicycle mul/div unit (forced to win after MAX_WAIT lost cycles)
// The winning address/data are registered together with the data-mux select,
// so an accepted request reaches the register file exactly one cycle later.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   stall                 write port unavailable this cycle (no grant)
//   a_valid/a_ready       source A request / accepted this cycle
//   a_addr, a_data        source A destination register and write data
//   b_valid/b_ready       source B request / accepted this cycle
//   b_addr, b_data        source B destination register and write data
//   sel                   registered mux select (0 = A path, 1 = B path)
//   rf_we                 registered register-file write enable
//   rf_waddr, rf_wdata    registered register-file write address / data
//   b_starved             high while the B wait counter is >= MAX_WAIT
// ---------------------------------------------------------------------------
module rf_wport_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              sel,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              b_starved
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Bit 0 of the encoding is the write enable, so rf_we comes straight
  // from a flop with no decode.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WR_A = 2'b01,
    WR_B = 2'b11
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_next;
  logic        grant_a;
  logic        grant_b;

  // Combinational grant. Readies are forced low while reset is asserted.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n && !stall) begin
      if (a_valid && b_valid) begin
        if (wait_cnt >= MAX_WAIT_C) grant_b = 1'b1;
        else                        grant_a = 1'b1;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Starvation counter: a stall freezes it, otherwise it restarts whenever B
  // is served or has nothing to write, and counts (saturating) each lost cycle.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!stall) begin
      if (!b_valid || grant_b)  wait_cnt_next = 4'd0;
      else if (wait_cnt != 4'hF) wait_cnt_next = wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      wait_cnt  <= 4'd0;
      b_starved <= 1'b0;
    end else begin
      // Writes to register 0 are consumed but never enabled; the select
      // still follows the winner so the mux tracks the last grant.
      if (grant_a) begin
        sel      <= 1'b0;
        rf_waddr <= a_addr;
        rf_wdata <= a_data;
        state    <= (a_addr != '0) ? WR_A : IDLE;
      end else if (grant_b) begin
        sel      <= 1'b1;
        rf_waddr <= b_addr;
        rf_wdata <= b_data;
        state    <= (b_addr != '0) ? WR_B : IDLE;
      end else begin
        state    <= IDLE;
      end
      wait_cnt  <= wait_cnt_next;
      b_starved <= (wait_cnt_next >= MAX_WAIT_C);
    end
  end

  assign rf_we = state[0];

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wport_arbiter
//
// Directed-vector bench with a scoreboard: each driven cycle pushes the
// hand-computed output expected one edge later; a separate monitor pops and
// compares after every rising edge. Readies are checked in the driven cycle.
// ---------------------------------------------------------------------------
module tb_rf_wport_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          a_valid = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic          b_valid = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data = '0;
  logic          a_ready;
  logic          b_ready;
  logic          sel;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          b_starved;

  rf_wport_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .sel(sel), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .b_starved(b_starved)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          starved;
    logic          chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per edge while the scoreboard holds entries.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rf_we", 32'(rf_we), 32'(e.we));
        check("sel", 32'(sel), 32'(e.sel));
        check("b_starved", 32'(b_starved), 32'(e.starved));
        if (e.chk_data) begin
          check("rf_waddr", 32'(rf_waddr), 32'(e.addr));
          check("rf_wdata", rf_wdata, e.data);
        end
        $display("out: we=%0d sel=%0d waddr=%0d wdata=0x%08h starved=%0d",
                 rf_we, sel, rf_waddr, rf_wdata, b_starved);
      end else if (rf_we) begin
        check("unexpected_write", 32'(rf_we), 32'd0);
      end
    end
  end

  // One driven cycle: inputs applied at the falling edge, readies checked,
  // expected registered outputs pushed for the next rising edge.
  task automatic cyc(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                     input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                     input logic st, input logic ear, input logic ebr,
                     input logic ewe, input logic esel, input logic [AW-1:0] eaddr,
                     input logic [DW-1:0] edata, input logic estv, input logic ecd);
    exp_t e;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    stall   = st;
    #1;
    check("a_ready", 32'(a_ready), 32'(ear));
    check("b_ready", 32'(b_ready), 32'(ebr));
    e.we = ewe; e.sel = esel; e.addr = eaddr; e.data = edata;
    e.starved = estv; e.chk_data = ecd;
    exp_q.push_back(e);
    $display("in: a=%0d/%0d b=%0d/%0d stall=%0d -> a_ready=%0d b_ready=%0d",
             av, aa, bv, ba, st, a_ready, b_ready);
  endtask

  task automatic idle(input logic esel, input logic [AW-1:0] eaddr, input logic [DW-1:0] edata);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, esel, eaddr, edata, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset with both sources requesting: everything stays zero.
    a_valid = 1'b1; b_valid = 1'b1;
    #12;
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_waddr", 32'(rf_waddr), 32'd0);
    check("reset_wdata", rf_wdata, 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_starved", 32'(b_starved), 32'd0);
    check("reset_a_ready", 32'(a_ready), 32'd0);
    check("reset_b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;

    // Single A write, then idle with held address/data.
    cyc(1, 5'd8, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 1, 0, 1, 0, 5'd8, 32'hDEADBEEF, 0, 1);
    idle(1'b0, 5'd8, 32'hDEADBEEF);

    // Contention: 3 A grants, forced B grant, repeat. Losing requests hold.
    cyc(1, 5'd1, 32'h101, 1, 5'd20, 32'hB0000000, 0, 1, 0, 1, 0, 5'd1,  32'h101,      0, 1);
    cyc(1, 5'd2, 32'h102, 1, 5'd20, 32'hB0000000, 0, 1, 0, 1, 0, 5'd2,  32'h102,      0, 1);
    cyc(1, 5'd3, 32'h103, 1, 5'd20, 32'hB0000000, 0, 1, 0, 1, 0, 5'd3,  32'h103,      1, 1);
    cyc(1, 5'd4, 32'h104, 1, 5'd20, 32'hB0000000, 0, 0, 1, 1, 1, 5'd20, 32'hB0000000, 0, 1);
    cyc(1, 5'd4, 32'h104, 1, 5'd20, 32'hB0000001, 0, 1, 0, 1, 0, 5'd4,  32'h104,      0, 1);
    cyc(1, 5'd5, 32'h105, 1, 5'd20, 32'hB0000001, 0, 1, 0, 1, 0, 5'd5,  32'h105,      0, 1);
    cyc(1, 5'd6, 32'h106, 1, 5'd20, 32'hB0000001, 0, 1, 0, 1, 0, 5'd6,  32'h106,      1, 1);
    cyc(1, 5'd7, 32'h107, 1, 5'd20, 32'hB0000001, 0, 0, 1, 1, 1, 5'd20, 32'hB0000001, 0, 1);
    idle(1'b1, 5'd20, 32'hB0000001);

    // Register-0 write: accepted, no write enable, select still moves to B.
    cyc(1, 5'd10, 32'hA10, 0, 5'd0, 32'h0,    0, 1, 0, 1, 0, 5'd10, 32'hA10,  0, 1);
    cyc(0, 5'd0,  32'h0,   1, 5'd0, 32'h1234, 0, 0, 1, 0, 1, 5'd0,  32'h0,    0, 0);
    cyc(0, 5'd0,  32'h0,   1, 5'd9, 32'h9999, 0, 0, 1, 1, 1, 5'd9,  32'h9999, 0, 1);
    idle(1'b1, 5'd9, 32'h9999);

    // Stall with both valid: nothing granted, outputs hold, then A wins.
    for (int i = 0; i < 4; i++)
      cyc(1, 5'd11, 32'h11, 1, 5'd12, 32'h12, 1, 0, 0, 0, 1, 5'd9, 32'h9999, 0, 1);
    cyc(1, 5'd11, 32'h11, 1, 5'd12, 32'h12, 0, 1, 0, 1, 0, 5'd11, 32'h11, 0, 1);
    cyc(0, 5'd0,  32'h0,  1, 5'd12, 32'h12, 0, 0, 1, 1, 1, 5'd12, 32'h12, 0, 1);
    idle(1'b1, 5'd12, 32'h12);

    // Back-to-back B writes keep rf_we high.
    cyc(0, 5'd0, 32'h0, 1, 5'd2, 32'h202, 0, 0, 1, 1, 1, 5'd2, 32'h202, 0, 1);
    cyc(0, 5'd0, 32'h0, 1, 5'd3, 32'h203, 0, 0, 1, 1, 1, 5'd3, 32'h203, 0, 1);
    cyc(0, 5'd0, 32'h0, 1, 5'd4, 32'h204, 0, 0, 1, 1, 1, 5'd4, 32'h204, 0, 1);
    idle(1'b1, 5'd4, 32'h204);

    // Reset asserted mid-cycle while an A write sits in the output register.
    cyc(1, 5'd5, 32'h55, 0, 5'd0, 32'h0, 0, 1, 0, 1, 0, 5'd5, 32'h55, 0, 1);
    @(posedge clk);
    #3;
    b_valid = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("midreset_rf_we", 32'(rf_we), 32'd0);
    check("midreset_waddr", 32'(rf_waddr), 32'd0);
    check("midreset_wdata", rf_wdata, 32'd0);
    check("midreset_sel", 32'(sel), 32'd0);
    check("midreset_a_ready", 32'(a_ready), 32'd0);
    check("midreset_b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    idle(1'b0, 5'd0, 32'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
